if_fetch_unit: RTL and testbench

//  Instruction-fetch stage between the PC register and the ID stage. Issues PC to instruction memory
//  (valid/ready request, variable-latency in-order response) and tracks in-flight fetches. Queues

---
 rtl/if_fetch_unit.sv | 161 ++++++++++++++++
 tb/tb_if_fetch_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: credit-limited requests to instruction memory, in-order response FIFO to IF/ID.
// Define IF_FETCH_PERF_EN to add the perf_fetch_cnt / perf_stall_cnt counters.
module if_fetch_unit #(
    parameter int INST_WIDTH      = 32,
    parameter int INST_ADDR_WIDTH = 32,
    parameter int FQ_DEPTH        = 2
) (
    input  logic                       cpu_clk,
    input  logic                       cpu_rst_n,
    input  logic [INST_ADDR_WIDTH-1:0] PC,
    output logic                       stall_PC_IF,
    input  logic                       flush,
    output logic                       imem_req_valid,
    output logic [INST_ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                       imem_req_ready,
    input  logic                       imem_rsp_valid,
    input  logic [INST_WIDTH-1:0]      imem_rsp_data,
    input  logic                       stall_IF_ID,
    output logic                       IF_ID_valid,
    output logic [INST_ADDR_WIDTH-1:0] IF_ID_PC,
`ifdef IF_FETCH_PERF_EN
    output logic [31:0]                perf_fetch_cnt,
    output logic [31:0]                perf_stall_cnt,
`endif
    output logic [INST_WIDTH-1:0]      IF_ID_inst
);

    localparam int PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    logic [INST_ADDR_WIDTH-1:0] fq_pc   [FQ_DEPTH];
    logic [INST_WIDTH-1:0]      fq_inst [FQ_DEPTH];
    logic [INST_ADDR_WIDTH-1:0] tag_q   [FQ_DEPTH];

    ptr_t fq_wr_ptr;
    ptr_t fq_rd_ptr;
    ptr_t tag_wr_ptr;
    ptr_t tag_rd_ptr;
    cnt_t fifo_count;
    cnt_t outstanding;
    cnt_t drop_cnt;

    logic [CNT_W:0] in_use;
    logic           credit_ok;
    logic           accept;
    logic           rsp_ok;
    logic           rsp_drop;
    logic           fq_push;
    logic           fq_pop;

    // Handshake: a request transfers on a cycle where imem_req_valid && imem_req_ready;
    // responses carry no ready and arrive in order, one per accepted request.
    // Every accepted request already owns a FIFO slot, so the FIFO can never overflow.
    assign in_use         = {1'b0, outstanding} + {1'b0, fifo_count};
    assign credit_ok      = in_use < (CNT_W+1)'(FQ_DEPTH);
    assign imem_req_valid = cpu_rst_n && !flush && credit_ok;
    assign imem_req_addr  = PC;
    assign accept         = imem_req_valid && imem_req_ready;
    assign stall_PC_IF    = !accept;

    assign rsp_ok   = imem_rsp_valid && (outstanding != '0);
    assign rsp_drop = flush || (drop_cnt != '0);
    assign fq_push  = rsp_ok && !rsp_drop;
    assign fq_pop   = IF_ID_valid && !stall_IF_ID && !flush;

    assign IF_ID_valid = (fifo_count != '0);
    assign IF_ID_PC    = fq_pc[fq_rd_ptr];
    assign IF_ID_inst  = fq_inst[fq_rd_ptr];

    // PC tags of in-flight fetches, consumed in response order.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            tag_wr_ptr  <= '0;
            tag_rd_ptr  <= '0;
            outstanding <= '0;
            for (int i = 0; i < FQ_DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                tag_q[tag_wr_ptr] <= PC;
                tag_wr_ptr        <= tag_wr_ptr + 1'b1;
            end
            if (rsp_ok) begin
                tag_rd_ptr <= tag_rd_ptr + 1'b1;
            end
            case ({accept, rsp_ok})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // On flush every fetch still in flight after this cycle belongs to the wrong path.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            drop_cnt <= '0;
        end else if (flush) begin
            drop_cnt <= rsp_ok ? outstanding - 1'b1 : outstanding;
        end else if (rsp_ok && (drop_cnt != '0)) begin
            drop_cnt <= drop_cnt - 1'b1;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            fq_wr_ptr  <= '0;
            fq_rd_ptr  <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FQ_DEPTH; i++) begin
                fq_pc[i]   <= '0;
                fq_inst[i] <= '0;
            end
        end else if (flush) begin
            fq_wr_ptr  <= '0;
            fq_rd_ptr  <= '0;
            fifo_count <= '0;
        end else begin
            if (fq_push) begin
                fq_pc[fq_wr_ptr]   <= tag_q[tag_rd_ptr];
                fq_inst[fq_wr_ptr] <= imem_rsp_data;
                fq_wr_ptr          <= fq_wr_ptr + 1'b1;
            end
            if (fq_pop) begin
                fq_rd_ptr <= fq_rd_ptr + 1'b1;
            end
            case ({fq_push, fq_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

`ifdef IF_FETCH_PERF_EN
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (accept) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (!IF_ID_valid && !flush) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

    a_fifo_bound: assert property (@(posedge cpu_clk) disable iff (!cpu_rst_n)
        fifo_count <= cnt_t'(FQ_DEPTH));

    a_rsp_has_req: assert property (@(posedge cpu_clk) disable iff (!cpu_rst_n)
        imem_rsp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit: fetch-queue reference model plus an expected-output scoreboard.
module tb_if_fetch_unit;

    localparam int IW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 2;

    logic          cpu_clk = 1'b0;
    logic          cpu_rst_n;
    logic [AW-1:0] PC;
    logic          stall_PC_IF;
    logic          flush;
    logic          imem_req_valid;
    logic [AW-1:0] imem_req_addr;
    logic          imem_req_ready;
    logic          imem_rsp_valid;
    logic [IW-1:0] imem_rsp_data;
    logic          stall_IF_ID;
    logic          IF_ID_valid;
    logic [AW-1:0] IF_ID_PC;
    logic [IW-1:0] IF_ID_inst;
`ifdef IF_FETCH_PERF_EN
    logic [31:0]   perf_fetch_cnt;
    logic [31:0]   perf_stall_cnt;
`endif

    if_fetch_unit #(
        .INST_WIDTH      (IW),
        .INST_ADDR_WIDTH (AW),
        .FQ_DEPTH        (DEPTH)
    ) dut (
        .cpu_clk        (cpu_clk),
        .cpu_rst_n      (cpu_rst_n),
        .PC             (PC),
        .stall_PC_IF    (stall_PC_IF),
        .flush          (flush),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .stall_IF_ID    (stall_IF_ID),
        .IF_ID_valid    (IF_ID_valid),
        .IF_ID_PC       (IF_ID_PC),
`ifdef IF_FETCH_PERF_EN
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .IF_ID_inst     (IF_ID_inst)
    );

    // clock / reset
    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic [AW-1:0] pc;
        logic [IW-1:0] inst;
        bit            dropped;
        int            due;
    } fetch_t;

    fetch_t              inflight[$];
    logic [AW+IW-1:0]    exp_q[$];
    logic [AW-1:0]       pc_reg;
    int                  cyc     = 0;
    int                  n_acc   = 0;
    int                  checks  = 0;
    int                  errors  = 0;

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        return a * 32'h0019_660D + 32'h3C6E_F35F;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // driver + reference model: one call per clock cycle
    task automatic run_cycles(input int n, input int rdy_pct, input int lat_min, input int lat_max,
                              input int stall_pct, input int flush_pct);
        for (int k = 0; k < n; k++) begin
            bit     fl;
            bit     rsp;
            bit     exp_rv;
            bit     acc;
            fetch_t f;
            @(negedge cpu_clk);
            fl             = ($urandom_range(0, 99) < flush_pct);
            flush          = fl;
            imem_req_ready = ($urandom_range(0, 99) < rdy_pct);
            stall_IF_ID    = ($urandom_range(0, 99) < stall_pct);
            PC             = pc_reg;
            rsp            = (inflight.size() > 0) && (inflight[0].due <= cyc);
            imem_rsp_valid = rsp;
            imem_rsp_data  = rsp ? inflight[0].inst : $urandom();
            #1;
            exp_rv = !fl && ((inflight.size() + exp_q.size()) < DEPTH);
            acc    = exp_rv && imem_req_ready;
            check("req_valid", 64'(imem_req_valid), 64'(exp_rv));
            check("stall_pc_if", 64'(stall_PC_IF), 64'(!acc));
            if (exp_rv) check("req_addr", 64'(imem_req_addr), 64'(pc_reg));
            check("if_id_valid", 64'(IF_ID_valid), 64'(exp_q.size() != 0));
            #2;
            if (fl) exp_q.delete();
            if (rsp) begin
                f = inflight.pop_front();
                if (!fl && !f.dropped) exp_q.push_back({f.pc, f.inst});
            end
            if (fl) begin
                foreach (inflight[i]) inflight[i].dropped = 1'b1;
            end
            if (acc) begin
                f.pc      = pc_reg;
                f.inst    = mem_word(pc_reg);
                f.dropped = 1'b0;
                f.due     = cyc + int'($urandom_range(lat_min, lat_max));
                inflight.push_back(f);
                pc_reg = pc_reg + 32'd4;
                n_acc++;
            end
            if (fl) pc_reg = $urandom() & 32'h0000_FFFC;
            cyc++;
        end
    endtask

    task automatic mid_reset();
        @(posedge cpu_clk);
        #2;
        cpu_rst_n = 1'b0;
        #1;
        check("rst_if_id_valid", 64'(IF_ID_valid), 64'd0);
        check("rst_req_valid", 64'(imem_req_valid), 64'd0);
        check("rst_if_id_pc", 64'(IF_ID_PC), 64'd0);
        check("rst_if_id_inst", 64'(IF_ID_inst), 64'd0);
        check("rst_stall_pc_if", 64'(stall_PC_IF), 64'd1);
        inflight.delete();
        exp_q.delete();
        pc_reg         = '0;
        n_acc          = 0;
        PC             = '0;
        flush          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        stall_IF_ID    = 1'b0;
        @(negedge cpu_clk);
        cpu_rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (inflight.size() != 0 || exp_q.size() != 0); i++) begin
            run_cycles(1, 0, 1, 1, 0, 0);
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    // scoreboard monitor: compares the presented head, pops on a real IF/ID transfer
    initial begin
        forever begin
            @(negedge cpu_clk);
            #2;
            if (cpu_rst_n && IF_ID_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL if_id_unexpected actual=pc %0h required=no entry (t=%0t)", IF_ID_PC, $time);
                end else begin
                    check("if_id_pc", 64'(IF_ID_PC), 64'(exp_q[0][AW+IW-1:IW]));
                    check("if_id_inst", 64'(IF_ID_inst), 64'(exp_q[0][IW-1:0]));
                    if (!stall_IF_ID && !flush) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        cpu_rst_n      = 1'b0;
        PC             = '0;
        flush          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        stall_IF_ID    = 1'b0;
        pc_reg         = '0;
        #1;
        check("init_if_id_valid", 64'(IF_ID_valid), 64'd0);
        check("init_req_valid", 64'(imem_req_valid), 64'd0);
        check("init_if_id_pc", 64'(IF_ID_PC), 64'd0);
        check("init_if_id_inst", 64'(IF_ID_inst), 64'd0);
        @(negedge cpu_clk);
        cpu_rst_n = 1'b1;

        run_cycles(30, 100, 1, 1, 0, 0);      // 0-wait streaming
        run_cycles(40, 100, 3, 3, 0, 0);      // latency 3, credit-limited
        run_cycles(4, 100, 1, 1, 0, 0);
        run_cycles(5, 100, 1, 1, 100, 0);     // ID stall with full FIFO
        run_cycles(10, 100, 1, 1, 0, 0);
        run_cycles(300, 70, 1, 4, 30, 10);    // random mix with flushes
        mid_reset();
        run_cycles(200, 80, 1, 5, 25, 8);
        drain();
`ifdef IF_FETCH_PERF_EN
        check("perf_fetch_cnt", 64'(perf_fetch_cnt), 64'(n_acc));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
